snn_weight_loader: RTL and testbench

Streaming write-side front end for the SNN weight memory. Accepts weight data as narrow beats over a valid/ready stream, packs them into full memory rows, and drives the memory write port (`waddr`, `w_en`, `data_in`) with one write per completed row, starting at a programmable base address. Sits between the SoC host/DMA path and the weight memory. It lets weights be (re)loaded at run time instead of only through the `weight.mem` initial image.

---
 rtl/snn_pkg.sv | 14 +
 rtl/snn_weight_loader_beat_packer.sv | 54 +++++
 rtl/snn_weight_loader.sv | 126 ++++++++++++
 tb/tb_snn_weight_loader.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared SNN definitions: default weight-memory geometry and the loader FSM state type.
package snn_pkg;

    localparam int SNN_WIDTH = 16;
    localparam int SNN_DEPTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } loader_state_t;

endpackage

// File: rtl/snn_weight_loader_beat_packer.sv
// beat_packer: packs IN_W-bit beats MSB first into DEPTH-bit rows and flags the row on its last beat.
module beat_packer #(
    parameter int DEPTH = 8,
    parameter int IN_W  = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             beat_valid,
    input  logic [IN_W-1:0]  beat_data,
    output logic             row_valid,
    output logic [DEPTH-1:0] row_data
);

    localparam int BPR = DEPTH / IN_W;
    localparam int CW  = (BPR > 1) ? $clog2(BPR) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BPR - 1);

    logic [CW-1:0] r_beat_cnt;

    assign row_valid = beat_valid && (r_beat_cnt == LAST_BEAT);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_beat_cnt <= '0;
        end else if (clear) begin
            r_beat_cnt <= '0;
        end else if (beat_valid) begin
            r_beat_cnt <= row_valid ? '0 : r_beat_cnt + 1'b1;
        end
    end

    generate
        if (BPR > 1) begin : g_shift
            // Holds only the earlier beats; the current beat completes the row combinationally.
            logic [DEPTH-IN_W-1:0] r_shift;

            assign row_data = {r_shift, beat_data};

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    r_shift <= '0;
                end else if (clear) begin
                    r_shift <= '0;
                end else if (beat_valid) begin
                    r_shift <= row_data[DEPTH-IN_W-1:0];
                end
            end
        end else begin : g_pass
            assign row_data = beat_data;
        end
    endgenerate

endmodule

// File: rtl/snn_weight_loader.sv
// Streaming weight loader: packs stream beats into rows and writes them from a base address.
// Optional row checksum enabled by defining SNN_WEIGHT_LOADER_CHECKSUM_EN.
module snn_weight_loader
    import snn_pkg::*;
#(
    parameter int WIDTH = SNN_WIDTH,
    parameter int DEPTH = SNN_DEPTH,
    parameter int IN_W  = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic [$clog2(WIDTH)-1:0] base_addr,
    input  logic [$clog2(WIDTH):0]   count,
    input  logic                     s_valid,
    input  logic [IN_W-1:0]          s_data,
    output logic                     s_ready,
    output logic [$clog2(WIDTH)-1:0] mem_waddr,
    output logic                     mem_w_en,
    output logic [DEPTH-1:0]         mem_data,
    output logic                     busy,
    output logic                     done,
    output logic [DEPTH-1:0]         checksum
);

    localparam int AW = $clog2(WIDTH);
    localparam logic [AW:0]   ROWS_MAX  = (AW+1)'(WIDTH);
    localparam logic [AW-1:0] ADDR_LAST = AW'(WIDTH - 1);

    loader_state_t    r_state;
    loader_state_t    w_state_next;
    logic [AW-1:0]    r_addr;
    logic [AW-1:0]    r_waddr;
    logic [AW:0]      r_rows_left;
    logic             r_wen;
    logic [DEPTH-1:0] r_data;
    logic [AW:0]      w_count_eff;
    logic             w_start;
    logic             w_accept;
    logic             w_row_valid;
    logic [DEPTH-1:0] w_row_data;

    assign w_start     = start && (r_state == IDLE);
    assign w_accept    = s_valid && (r_state == LOAD);
    assign w_count_eff = (count > ROWS_MAX) ? ROWS_MAX : count;

    assign s_ready   = (r_state == LOAD);
    assign busy      = (r_state != IDLE);
    assign done      = (r_state == DONE);
    assign mem_waddr = r_waddr;
    assign mem_w_en  = r_wen;
    assign mem_data  = r_data;

    beat_packer #(
        .DEPTH (DEPTH),
        .IN_W  (IN_W)
    ) u_packer (
        .clock      (clock),
        .reset_n    (reset_n),
        .clear      (w_start),
        .beat_valid (w_accept),
        .beat_data  (s_data),
        .row_valid  (w_row_valid),
        .row_data   (w_row_data)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = (count == '0) ? DONE : LOAD;
            LOAD:    if (w_row_valid && (r_rows_left == (AW+1)'(1))) w_state_next = DRAIN;
            DRAIN:   w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_addr      <= '0;
            r_waddr     <= '0;
            r_rows_left <= '0;
            r_wen       <= 1'b0;
            r_data      <= '0;
        end else begin
            r_wen <= 1'b0;
            if (w_start) begin
                r_addr      <= base_addr;
                r_rows_left <= w_count_eff;
            end else if (w_row_valid) begin
                r_data      <= w_row_data;
                r_waddr     <= r_addr;
                r_wen       <= 1'b1;
                r_addr      <= (r_addr == ADDR_LAST) ? '0 : r_addr + 1'b1;
                r_rows_left <= r_rows_left - 1'b1;
            end
        end
    end

`ifdef SNN_WEIGHT_LOADER_CHECKSUM_EN
    logic [DEPTH-1:0] r_checksum;

    assign checksum = r_checksum;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_checksum <= '0;
        end else if (w_start) begin
            r_checksum <= '0;
        end else if (w_row_valid) begin
            r_checksum <= r_checksum ^ w_row_data;
        end
    end
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_snn_weight_loader.sv
// Directed testbench for snn_weight_loader with a behavioural weight memory on the write port.
module tb_snn_weight_loader;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] base_addr = '0;
    logic [4:0] count = '0;
    logic       s_valid = 1'b0;
    logic [3:0] s_data = '0;
    logic       s_ready;
    logic [3:0] mem_waddr;
    logic       mem_w_en;
    logic [7:0] mem_data;
    logic       busy;
    logic       done;
    logic [7:0] checksum;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wen_cnt = 0;
    int done_cnt = 0;
    logic [7:0] mem [16] = '{default: 8'h5A};

`ifdef SNN_WEIGHT_LOADER_CHECKSUM_EN
    localparam bit CK_EN = 1'b1;
`else
    localparam bit CK_EN = 1'b0;
`endif

    snn_weight_loader dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .base_addr (base_addr),
        .count     (count),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .mem_waddr (mem_waddr),
        .mem_w_en  (mem_w_en),
        .mem_data  (mem_data),
        .busy      (busy),
        .done      (done),
        .checksum  (checksum)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (mem_w_en) begin
            mem[mem_waddr] <= mem_data;
            wen_cnt <= wen_cnt + 1;
        end
        if (done) done_cnt <= done_cnt + 1;
    end

    // All drivers run from a negedge; s_cyc is the cycle counter before the start edge.
    task automatic do_start(input logic [3:0] b, input logic [4:0] n, output int s_cyc);
        start = 1'b1; base_addr = b; count = n; s_cyc = cyc;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic send_beat(input logic [3:0] d);
        int t = 0;
        s_valid = 1'b1; s_data = d;
        while (!s_ready && t < 50) begin @(negedge clock); t++; end
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL beat_ready_timeout got=%b exp=1", s_ready); end
        @(negedge clock);
        s_valid = 1'b0;
    endtask

    // Returns the latency in cycles counting the start cycle as cycle 1.
    task automatic wait_done(input int s_cyc, output int lat);
        int t = 0;
        while (!done && t < 200) begin @(negedge clock); t++; end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL done_timeout got=%b exp=1", done); end
        lat = cyc - s_cyc + 1;
        @(negedge clock);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clock);
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL rst_s_ready got=%b exp=0", s_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got=%b exp=0", done); end
        checks++; if (mem_w_en !== 1'b0) begin errors++; $display("FAIL rst_w_en got=%b exp=0", mem_w_en); end
        checks++; if ({mem_waddr, mem_data, checksum} !== 20'h0) begin errors++; $display("FAIL rst_data got=%h exp=0", {mem_waddr, mem_data, checksum}); end
        reset_n = 1'b1;
        @(negedge clock);
        checks++; if ({s_ready, busy, done, mem_w_en} !== 4'b0) begin errors++; $display("FAIL idle_flags got=%b exp=0000", {s_ready, busy, done, mem_w_en}); end
        $display("reset: outputs checked");
    endtask

    task automatic test_basic();
        int s, lat, w0, d0;
        w0 = wen_cnt; d0 = done_cnt;
        do_start(4'd2, 5'd2, s);
        checks++; if ({s_ready, busy} !== 2'b11) begin errors++; $display("FAIL basic_first_ready got=%b exp=11", {s_ready, busy}); end
        send_beat(4'hA); send_beat(4'h5); send_beat(4'h3); send_beat(4'hC);
        checks++; if ({mem_w_en, mem_waddr, mem_data, s_ready} !== {1'b1, 4'd3, 8'h3C, 1'b0}) begin errors++; $display("FAIL basic_last_write got=%h exp=%h", {mem_w_en, mem_waddr, mem_data, s_ready}, {1'b1, 4'd3, 8'h3C, 1'b0}); end
        wait_done(s, lat);
        checks++; if (lat !== 7) begin errors++; $display("FAIL basic_latency got=%0d exp=7", lat); end
        checks++; if (mem[2] !== 8'hA5) begin errors++; $display("FAIL basic_row2 got=%h exp=a5", mem[2]); end
        checks++; if (mem[3] !== 8'h3C) begin errors++; $display("FAIL basic_row3 got=%h exp=3c", mem[3]); end
        checks++; if (wen_cnt - w0 !== 2) begin errors++; $display("FAIL basic_wen_count got=%0d exp=2", wen_cnt - w0); end
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL basic_done_count got=%0d exp=1", done_cnt - d0); end
        checks++; if (checksum !== (CK_EN ? 8'h99 : 8'h00)) begin errors++; $display("FAIL basic_checksum got=%h exp=%h", checksum, CK_EN ? 8'h99 : 8'h00); end
        $display("basic load: base=2 count=2 latency=%0d", lat);
    endtask

    task automatic test_wrap();
        int s, lat;
        logic [7:0] snap [16];
        for (int i = 0; i < 16; i++) snap[i] = mem[i];
        do_start(4'd15, 5'd2, s);
        send_beat(4'h1); send_beat(4'h1); send_beat(4'h2); send_beat(4'h2);
        wait_done(s, lat);
        checks++; if (mem[15] !== 8'h11) begin errors++; $display("FAIL wrap_row15 got=%h exp=11", mem[15]); end
        checks++; if (mem[0] !== 8'h22) begin errors++; $display("FAIL wrap_row0 got=%h exp=22", mem[0]); end
        for (int i = 1; i < 15; i++) begin
            checks++; if (mem[i] !== snap[i]) begin errors++; $display("FAIL wrap_untouched_row%0d got=%h exp=%h", i, mem[i], snap[i]); end
        end
        checks++; if (checksum !== (CK_EN ? 8'h33 : 8'h00)) begin errors++; $display("FAIL wrap_checksum got=%h exp=%h", checksum, CK_EN ? 8'h33 : 8'h00); end
        $display("wrap load: base=15 count=2 latency=%0d", lat);
    endtask

    task automatic test_stall();
        int s, lat, w0;
        do_start(4'd6, 5'd2, s);
        send_beat(4'hA);
        w0 = wen_cnt;
        repeat (3) @(negedge clock);
        checks++; if (wen_cnt - w0 !== 0) begin errors++; $display("FAIL stall_wen got=%0d exp=0", wen_cnt - w0); end
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL stall_ready got=%b exp=1", s_ready); end
        send_beat(4'h5); send_beat(4'h3); send_beat(4'hC);
        wait_done(s, lat);
        checks++; if (lat !== 10) begin errors++; $display("FAIL stall_latency got=%0d exp=10", lat); end
        checks++; if ({mem[6], mem[7]} !== 16'hA53C) begin errors++; $display("FAIL stall_rows got=%h exp=a53c", {mem[6], mem[7]}); end
        $display("stall load: base=6 count=2 latency=%0d", lat);
    endtask

    task automatic test_count_zero_and_saturation();
        int s, lat, w0, d0;
        logic [3:0] hi, lo;
        w0 = wen_cnt; d0 = done_cnt;
        do_start(4'd4, 5'd0, s);
        wait_done(s, lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL zero_latency got=%0d exp=2", lat); end
        checks++; if (wen_cnt - w0 !== 0) begin errors++; $display("FAIL zero_wen got=%0d exp=0", wen_cnt - w0); end
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL zero_done got=%0d exp=1", done_cnt - d0); end
        $display("zero load: count=0 latency=%0d", lat);
        w0 = wen_cnt;
        do_start(4'd0, 5'd20, s);
        for (int i = 0; i < 16; i++) begin
            hi = 4'(i); lo = 4'(15 - i);
            send_beat(hi); send_beat(lo);
        end
        wait_done(s, lat);
        checks++; if (lat !== 35) begin errors++; $display("FAIL sat_latency got=%0d exp=35", lat); end
        checks++; if (wen_cnt - w0 !== 16) begin errors++; $display("FAIL sat_wen got=%0d exp=16", wen_cnt - w0); end
        for (int i = 0; i < 16; i++) begin
            hi = 4'(i); lo = 4'(15 - i);
            checks++; if (mem[i] !== {hi, lo}) begin errors++; $display("FAIL sat_row%0d got=%h exp=%h", i, mem[i], {hi, lo}); end
        end
        $display("saturated load: count=20 writes=%0d", wen_cnt - w0);
    endtask

    task automatic test_start_busy();
        int s, lat, w0, d0;
        logic [7:0] row0;
        row0 = mem[0]; w0 = wen_cnt; d0 = done_cnt;
        do_start(4'd8, 5'd2, s);
        send_beat(4'h1);
        start = 1'b1; base_addr = 4'd0; count = 5'd5;
        send_beat(4'h2);
        start = 1'b0;
        send_beat(4'h3); send_beat(4'h4);
        wait_done(s, lat);
        repeat (10) @(negedge clock);
        checks++; if (wen_cnt - w0 !== 2) begin errors++; $display("FAIL busy_wen got=%0d exp=2", wen_cnt - w0); end
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL busy_done got=%0d exp=1", done_cnt - d0); end
        checks++; if ({mem[8], mem[9]} !== 16'h1234) begin errors++; $display("FAIL busy_rows got=%h exp=1234", {mem[8], mem[9]}); end
        checks++; if (mem[0] !== row0) begin errors++; $display("FAIL busy_row0 got=%h exp=%h", mem[0], row0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_idle got=%b exp=0", busy); end
        $display("start while busy: writes=%0d dones=%0d", wen_cnt - w0, done_cnt - d0);
    endtask

    task automatic test_reset_mid_row();
        int s, lat, w0;
        logic [7:0] row10;
        row10 = mem[10];
        do_start(4'd10, 5'd2, s);
        send_beat(4'hE);
        w0 = wen_cnt;
        reset_n = 1'b0;
        #1;
        checks++; if ({s_ready, busy, done, mem_w_en} !== 4'b0) begin errors++; $display("FAIL midrst_flags got=%b exp=0000", {s_ready, busy, done, mem_w_en}); end
        checks++; if ({mem_waddr, mem_data, checksum} !== 20'h0) begin errors++; $display("FAIL midrst_data got=%h exp=0", {mem_waddr, mem_data, checksum}); end
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        checks++; if (wen_cnt - w0 !== 0) begin errors++; $display("FAIL midrst_wen got=%0d exp=0", wen_cnt - w0); end
        checks++; if (mem[10] !== row10) begin errors++; $display("FAIL midrst_row10 got=%h exp=%h", mem[10], row10); end
        do_start(4'd10, 5'd1, s);
        send_beat(4'h7); send_beat(4'h8);
        wait_done(s, lat);
        checks++; if (lat !== 5) begin errors++; $display("FAIL postrst_latency got=%0d exp=5", lat); end
        checks++; if (mem[10] !== 8'h78) begin errors++; $display("FAIL postrst_row10 got=%h exp=78", mem[10]); end
        checks++; if (checksum !== (CK_EN ? 8'h78 : 8'h00)) begin errors++; $display("FAIL postrst_checksum got=%h exp=%h", checksum, CK_EN ? 8'h78 : 8'h00); end
        $display("reset mid-row then reload: row10=%h", mem[10]);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_stall();
        test_count_zero_and_saturation();
        test_start_busy();
        test_reset_mid_row();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
